// File: rtl/axi_stream_input.sv
// AXI4-Stream ingress: writes a frame of signed activation bytes into the input SRAM from
// address 0, checking the beat count against in_row*in_col and the tlast position.
module axi_stream_input #(
    parameter int ADDR_WIDTH         = 13,
    parameter int DATA_WIDTH         = 8,
    parameter int NUM_CHANNELS_WIDTH = $clog2(64 + 1)
) (
    input  logic                          s_axis_aclk,
    input  logic                          s_axis_aresetn,
    input  logic signed [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    input  logic [NUM_CHANNELS_WIDTH-1:0] s_axis_tuser,
    output logic                          sram_in_en,
    output logic                          sram_in_we,
    output logic [ADDR_WIDTH-1:0]         sram_in_addr,
    output logic signed [DATA_WIDTH-1:0]  sram_in_data_in,
    input  logic                          start_input,
    input  logic [ADDR_WIDTH-1:0]         in_row,
    input  logic [ADDR_WIDTH-1:0]         in_col,
    output logic                          input_done,
    output logic                          length_error,
    output logic [ADDR_WIDTH:0]           recv_count,
    output logic [NUM_CHANNELS_WIDTH-1:0] in_channels
);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_e;

    localparam int TOTAL_WIDTH = 2 * ADDR_WIDTH;
    localparam logic [TOTAL_WIDTH-1:0] MAX_BEATS = TOTAL_WIDTH'(1) << ADDR_WIDTH;

    state_e                          state_q, state_d;
    logic [TOTAL_WIDTH-1:0]          last_idx_q, last_idx_d;
    logic [ADDR_WIDTH:0]             recv_count_q, recv_count_d;
    logic                            sram_en_q, sram_en_d;
    logic                            sram_we_q, sram_we_d;
    logic [ADDR_WIDTH-1:0]           sram_addr_q, sram_addr_d;
    logic signed [DATA_WIDTH-1:0]    sram_data_q, sram_data_d;
    logic                            input_done_q, input_done_d;
    logic                            length_error_q, length_error_d;
    logic [NUM_CHANNELS_WIDTH-1:0]   in_channels_q, in_channels_d;

    logic [TOTAL_WIDTH-1:0]          product;
    logic [TOTAL_WIDTH-1:0]          count_ext;
    logic                            handshake;

    assign s_axis_tready = (state_q == RECV) && s_axis_aresetn;

    always_comb begin
        product   = {{ADDR_WIDTH{1'b0}}, in_row} * {{ADDR_WIDTH{1'b0}}, in_col};
        count_ext = {{(TOTAL_WIDTH - ADDR_WIDTH - 1){1'b0}}, recv_count_q};
        handshake = s_axis_tvalid && s_axis_tready;

        state_d        = state_q;
        last_idx_d     = last_idx_q;
        recv_count_d   = recv_count_q;
        sram_en_d      = 1'b0;
        sram_we_d      = 1'b0;
        sram_addr_d    = sram_addr_q;
        sram_data_d    = sram_data_q;
        input_done_d   = 1'b0;
        length_error_d = length_error_q;
        in_channels_d  = in_channels_q;

        case (state_q)
            IDLE: begin
                if (start_input) begin
                    // Index of the final beat is stored so RECV compares without a subtractor.
                    last_idx_d     = product - TOTAL_WIDTH'(1);
                    recv_count_d   = '0;
                    length_error_d = 1'b0;
                    if (product == '0) begin
                        state_d = DONE;
                    end else if (product > MAX_BEATS) begin
                        length_error_d = 1'b1;
                        state_d        = DONE;
                    end else begin
                        state_d = RECV;
                    end
                end
            end
            RECV: begin
                if (handshake) begin
                    sram_en_d    = 1'b1;
                    sram_we_d    = 1'b1;
                    sram_addr_d  = recv_count_q[ADDR_WIDTH-1:0];
                    sram_data_d  = s_axis_tdata;
                    recv_count_d = recv_count_q + (ADDR_WIDTH + 1)'(1);
                    if (recv_count_q == '0) begin
                        in_channels_d = s_axis_tuser;
                    end
                    if (count_ext == last_idx_q) begin
                        state_d = DONE;
                        if (!s_axis_tlast) begin
                            length_error_d = 1'b1;
                        end
                    end else if (s_axis_tlast) begin
                        length_error_d = 1'b1;
                        state_d        = DONE;
                    end
                end
            end
            DONE: begin
                state_d      = IDLE;
                input_done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            state_q        <= IDLE;
            last_idx_q     <= '0;
            recv_count_q   <= '0;
            sram_en_q      <= 1'b0;
            sram_we_q      <= 1'b0;
            sram_addr_q    <= '0;
            sram_data_q    <= '0;
            input_done_q   <= 1'b0;
            length_error_q <= 1'b0;
            in_channels_q  <= '0;
        end else begin
            state_q        <= state_d;
            last_idx_q     <= last_idx_d;
            recv_count_q   <= recv_count_d;
            sram_en_q      <= sram_en_d;
            sram_we_q      <= sram_we_d;
            sram_addr_q    <= sram_addr_d;
            sram_data_q    <= sram_data_d;
            input_done_q   <= input_done_d;
            length_error_q <= length_error_d;
            in_channels_q  <= in_channels_d;
        end
    end

    assign sram_in_en      = sram_en_q;
    assign sram_in_we      = sram_we_q;
    assign sram_in_addr    = sram_addr_q;
    assign sram_in_data_in = sram_data_q;
    assign input_done      = input_done_q;
    assign length_error    = length_error_q;
    assign recv_count      = recv_count_q;
    assign in_channels     = in_channels_q;

endmodule
